// File: rtl/rv_ctrl_pkg.sv
// Shared control encodings for the multicycle RV32I core: FSM states, opcodes,
// immediate-extender selects and datapath mux codes.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_UPPER    = 4'd12
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;

  // Immediate extender selects; the extender decodes the same values.
  localparam logic [2:0] IMM_NONE  = 3'b000;
  localparam logic [2:0] IMM_I     = 3'b001;
  localparam logic [2:0] IMM_S     = 3'b010;
  localparam logic [2:0] IMM_B     = 3'b011;
  localparam logic [2:0] IMM_J     = 3'b100;
  localparam logic [2:0] IMM_U     = 3'b110;
  localparam logic [2:0] IMM_SHIFT = 3'b111;

  localparam logic [1:0] ALU_SRC_A_PC    = 2'b00;
  localparam logic [1:0] ALU_SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] ALU_SRC_A_RS1   = 2'b10;

  localparam logic [1:0] ALU_SRC_B_RS2  = 2'b00;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'b01;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'b10;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] RESULT_ALUOUT = 2'b00;
  localparam logic [1:0] RESULT_MEM    = 2'b01;
  localparam logic [1:0] RESULT_ALU    = 2'b10;

  function automatic logic is_shift_f3(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation from ALU compare flags; flags reserved funct3 codes.
module branch_cond (
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken,
  output logic       bad
);

  always_comb begin
    taken = 1'b0;
    bad   = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: bad   = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/writeback over a
// shared ALU and unified memory port, stalling on mem_ready.
module multicycle_ctrl_fsm
  import rv_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        alu_ltu,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [2:0]  imm_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  result_src,
  output logic        illegal_instr
);

  state_e     state_q, state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       br_taken, br_bad;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31:15], instr[11:7]};

  branch_cond u_branch_cond (
    .funct3 (funct3),
    .zero   (alu_zero),
    .lt     (alu_lt),
    .ltu    (alu_ltu),
    .taken  (br_taken),
    .bad    (br_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= state_e'(RESET_STATE);
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    imm_src       = IMM_NONE;
    alu_src_a     = ALU_SRC_A_PC;
    alu_src_b     = ALU_SRC_B_RS2;
    alu_op        = ALU_OP_ADD;
    result_src    = RESULT_ALUOUT;
    illegal_instr = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = ALU_SRC_B_FOUR;
        result_src = RESULT_ALU;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut gets oldPC+imm: branch target, or jump target for JAL
        alu_src_a = ALU_SRC_A_OLDPC;
        alu_src_b = ALU_SRC_B_IMM;
        imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
          default: begin
            state_d       = S_FETCH;
            illegal_instr = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = ALU_SRC_A_RS1;
        alu_src_b = ALU_SRC_B_IMM;
        imm_src   = (opcode == OP_LOAD) ? IMM_I : IMM_S;
        state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RESULT_MEM;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = ALU_SRC_A_RS1;
        alu_op    = ALU_OP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = ALU_SRC_A_RS1;
        alu_src_b = ALU_SRC_B_IMM;
        alu_op    = ALU_OP_FUNCT;
        imm_src   = is_shift_f3(funct3) ? IMM_SHIFT : IMM_I;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = ALU_SRC_A_RS1;
        alu_op        = ALU_OP_SUB;
        pc_write      = br_taken;
        illegal_instr = br_bad;
        state_d       = S_FETCH;
      end
      S_JAL: begin
        // Link oldPC+4 lands in ALUOut while PC takes the DECODE-computed target
        alu_src_a = ALU_SRC_A_OLDPC;
        alu_src_b = ALU_SRC_B_FOUR;
        imm_src   = IMM_J;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = ALU_SRC_A_RS1;
        alu_src_b  = ALU_SRC_B_IMM;
        imm_src    = IMM_I;
        result_src = RESULT_ALU;
        pc_write   = 1'b1;
        state_d    = S_ALUWB;
      end
      S_UPPER: begin
        // LUI relies on the decoder forcing rs1 to x0
        alu_src_a = (opcode == OP_AUIPC) ? ALU_SRC_A_OLDPC : ALU_SRC_A_RS1;
        alu_src_b = ALU_SRC_B_IMM;
        imm_src   = IMM_U;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed plus randomized instruction streams checked cycle-by-cycle against an
// instruction-level model of the expected control sequence.
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_instr;
  logic [2:0]  imm_src;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed { logic [17:0] v; logic rdy; } cyc_t;
  cyc_t q[$];

  logic [17:0] obs;
  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                imm_src, alu_src_a, alu_src_b, alu_op, result_src, illegal_instr};

  multicycle_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .imm_src(imm_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] ov(input logic mr, mw, as, irw, pcw, rw,
                                     input logic [2:0] imm, input logic [1:0] sa, sb, op, res,
                                     input logic ill);
    return {mr, mw, as, irw, pcw, rw, imm, sa, sb, op, res, ill};
  endfunction

  function automatic logic [17:0] fetch_v(input logic ack);
    return ov(1, 0, 0, ack, ack, 0, 3'b000, 2'b00, 2'b10, 2'b00, 2'b10, 0);
  endfunction

  function automatic logic [17:0] aluwb_v();
    return ov(0, 0, 0, 0, 0, 1, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 0);
  endfunction

  task automatic check(input string tag, input logic [17:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    n_chk++;
    assert ((reg_write & mem_write) === 1'b0) else begin
      n_fail++;
      $error("FAIL %s excl: observed reg_write=%b mem_write=%b expected not both", tag, reg_write, mem_write);
    end
  endtask

  task automatic push(input logic [17:0] v, input logic r);
    q.push_back('{v: v, rdy: r});
  endtask

  // Instruction-level reference: expected control vector per cycle, from the ISA class.
  task automatic model(input logic [31:0] ins, input int wf, input int wm,
                       input logic [31:0] a, input logic [31:0] b);
    logic [6:0] opc;
    logic [2:0] f3;
    logic       legal, taken, bad, rnd;
    opc = ins[6:0];
    f3  = ins[14:12];
    legal = opc inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    rnd = 1'($urandom_range(0, 1));
    repeat (wf) push(fetch_v(0), 0);
    push(fetch_v(1), 1);
    push(ov(0, 0, 0, 0, 0, 0, (opc == 7'h6F) ? 3'b100 : 3'b011, 2'b01, 2'b01, 2'b00, 2'b00, !legal), rnd);
    case (opc)
      7'h03: begin
        push(ov(0, 0, 0, 0, 0, 0, 3'b001, 2'b10, 2'b01, 2'b00, 2'b00, 0), rnd);
        repeat (wm) push(ov(1, 0, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 0), 0);
        push(ov(1, 0, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1);
        push(ov(0, 0, 0, 0, 0, 1, 3'b000, 2'b00, 2'b00, 2'b00, 2'b01, 0), rnd);
      end
      7'h23: begin
        push(ov(0, 0, 0, 0, 0, 0, 3'b010, 2'b10, 2'b01, 2'b00, 2'b00, 0), rnd);
        repeat (wm) push(ov(1, 1, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 0), 0);
        push(ov(1, 1, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 2'b00, 0), 1);
      end
      7'h33: begin
        push(ov(0, 0, 0, 0, 0, 0, 3'b000, 2'b10, 2'b00, 2'b10, 2'b00, 0), rnd);
        push(aluwb_v(), rnd);
      end
      7'h13: begin
        push(ov(0, 0, 0, 0, 0, 0, (f3 == 3'd1 || f3 == 3'd5) ? 3'b111 : 3'b001,
                2'b10, 2'b01, 2'b10, 2'b00, 0), rnd);
        push(aluwb_v(), rnd);
      end
      7'h63: begin
        bad = 1'b0;
        case (f3)
          3'd0: taken = (a == b);
          3'd1: taken = (a != b);
          3'd4: taken = ($signed(a) < $signed(b));
          3'd5: taken = ($signed(a) >= $signed(b));
          3'd6: taken = (a < b);
          3'd7: taken = (a >= b);
          default: begin taken = 1'b0; bad = 1'b1; end
        endcase
        push(ov(0, 0, 0, 0, taken, 0, 3'b000, 2'b10, 2'b00, 2'b01, 2'b00, bad), rnd);
      end
      7'h6F: begin
        push(ov(0, 0, 0, 0, 1, 0, 3'b100, 2'b01, 2'b10, 2'b00, 2'b00, 0), rnd);
        push(aluwb_v(), rnd);
      end
      7'h67: begin
        push(ov(0, 0, 0, 0, 1, 0, 3'b001, 2'b10, 2'b01, 2'b00, 2'b10, 0), rnd);
        push(aluwb_v(), rnd);
      end
      7'h37, 7'h17: begin
        push(ov(0, 0, 0, 0, 0, 0, 3'b110, (opc == 7'h17) ? 2'b01 : 2'b10, 2'b01, 2'b00, 2'b00, 0), rnd);
        push(aluwb_v(), rnd);
      end
      default: ;
    endcase
  endtask

  // Entered and left at posedge+1 with the FSM in FETCH.
  task automatic run(input string tag, input logic [31:0] ins, input int wf, input int wm,
                     input logic [31:0] a, input logic [31:0] b);
    instr    = ins;
    alu_zero = (a == b);
    alu_lt   = ($signed(a) < $signed(b));
    alu_ltu  = (a < b);
    q.delete();
    model(ins, wf, wm, a, b);
    for (int i = 0; i < q.size(); i++) begin
      mem_ready = q[i].rdy;
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), q[i].v);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    logic [6:0]  bad_ops [5];
    logic [6:0]  good_ops[9];
    logic [31:0] ins, a, b;
    bad_ops  = '{7'h7F, 7'h00, 7'h0F, 7'h73, 7'h5B};
    good_ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    #3;
    check("reset", fetch_v(0));
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    run("lw_wait3", 32'h00412083, 0, 3, 32'd0, 32'd0);
    run("sw_wait2", 32'h00112223, 1, 2, 32'd0, 32'd0);
    run("beq_z",    32'h00000063, 0, 0, 32'd7, 32'd7);
    run("bne_z",    32'h00001063, 0, 0, 32'd7, 32'd7);
    run("br_f3_2",  32'h00002063, 0, 0, 32'd1, 32'd2);
    run("blt",      32'h00004063, 0, 0, 32'hFFFF_FFFF, 32'd1);
    run("bltu",     32'h00006063, 0, 0, 32'hFFFF_FFFF, 32'd1);
    run("slli",     32'h00309093, 0, 0, 32'd0, 32'd0);
    run("addi",     32'h00308093, 2, 0, 32'd0, 32'd0);
    run("add",      32'h002081B3, 0, 0, 32'd0, 32'd0);
    run("op7f",     32'h0000007F, 0, 0, 32'd0, 32'd0);
    run("jal",      32'h008000EF, 0, 0, 32'd0, 32'd0);
    run("jalr",     32'h000080E7, 0, 0, 32'd0, 32'd0);
    run("lui",      32'h123450B7, 0, 0, 32'd0, 32'd0);
    run("auipc",    32'h12345097, 0, 0, 32'd0, 32'd0);

    // Reset asserted while a load waits in MEMREAD
    instr = 32'h00412083;
    q.delete();
    model(instr, 0, 5, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      mem_ready = q[i].rdy;
      @(negedge clk);
      check($sformatf("rst_pre[%0d]", i), q[i].v);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1 check("rst_async", fetch_v(0));
    @(posedge clk); #1;
    check("rst_held", fetch_v(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_after", fetch_v(0));
    @(posedge clk); #1;

    for (int n = 0; n < 80; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 7) == 0) ins[6:0] = bad_ops[$urandom_range(0, 4)];
      else                           ins[6:0] = good_ops[$urandom_range(0, 8)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run($sformatf("rnd%0d_%h", n, ins), ins, $urandom_range(0, 3), $urandom_range(0, 3), a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
